// File: rtl/cpu_seq_if.sv
// Control/status bundle between cpu_sequencer and the ExceptioNull datapath.
// master = sequencer side, slave = datapath/memory side.
interface cpu_seq_if #(
  parameter int CNT_W = 8
);
  logic             run;
  logic             halt_req;
  logic             mem_r_en;
  logic             mem_w_en;
  logic             reg_w_en;
  logic             mem_ack;
  logic             fetch_stb;
  logic             decode_stb;
  logic             regrd_stb;
  logic             exec_stb;
  logic             mem_req;
  logic             wbsel_stb;
  logic             wb_stb;
  logic             pc_stb;
  logic [2:0]       state;
  logic             busy;
  logic             halted;
  logic             mem_err;
  logic [CNT_W-1:0] retired;

  modport master (
    input  run, halt_req, mem_r_en, mem_w_en, reg_w_en, mem_ack,
    output fetch_stb, decode_stb, regrd_stb, exec_stb, mem_req,
           wbsel_stb, wb_stb, pc_stb, state, busy, halted, mem_err, retired
  );

  modport slave (
    output run, halt_req, mem_r_en, mem_w_en, reg_w_en, mem_ack,
    input  fetch_stb, decode_stb, regrd_stb, exec_stb, mem_req,
           wbsel_stb, wb_stb, pc_stb, state, busy, halted, mem_err, retired
  );
endinterface

// File: rtl/cpu_sequencer.sv
// 8-state multi-cycle instruction sequencer with run/halt, memory timeout and retire counter.
// Optional macro MEM_SKIP_EN: instructions without a memory operation bypass the MEM state.
module cpu_sequencer #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 8
) (
  input  logic      clk,
  input  logic      rst_n,
  cpu_seq_if.master bus
);

  localparam logic [2:0] S_FETCH  = 3'b000;
  localparam logic [2:0] S_DECODE = 3'b001;
  localparam logic [2:0] S_REGRD  = 3'b010;
  localparam logic [2:0] S_EXEC   = 3'b011;
  localparam logic [2:0] S_MEM    = 3'b100;
  localparam logic [2:0] S_WBSEL  = 3'b101;
  localparam logic [2:0] S_WB     = 3'b110;
  localparam logic [2:0] S_PCUPD  = 3'b111;

  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  logic [2:0]       state_q,   state_d;
  logic [7:0]       wait_q,    wait_d;
  logic             mem_op_q,  mem_op_d;
  logic             wr_q,      wr_d;
  logic             halted_q,  halted_d;
  logic             mem_err_q, mem_err_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    mem_op_d  = mem_op_q;
    wr_d      = wr_q;
    halted_d  = halted_q;
    mem_err_d = mem_err_q;
    retired_d = retired_q;
    case (state_q)
      S_FETCH: begin
        if (bus.run && !halted_q) state_d = S_DECODE;
      end
      S_DECODE: state_d = S_REGRD;
      S_REGRD:  state_d = S_EXEC;
      S_EXEC: begin
        mem_op_d = bus.mem_r_en | bus.mem_w_en;
        wr_d     = bus.reg_w_en;
`ifdef MEM_SKIP_EN
        state_d  = (bus.mem_r_en | bus.mem_w_en) ? S_MEM : S_WBSEL;
`else
        state_d  = S_MEM;
`endif
      end
      S_MEM: begin
        if (!mem_op_q) begin
          state_d = S_WBSEL;
        end else if (bus.mem_ack) begin
          state_d = S_WBSEL;
          wait_d  = 8'd0;
        end else if (wait_q == WAIT_LAST) begin
          // Abort: the instruction is dropped without PC update or retire.
          state_d   = S_FETCH;
          wait_d    = 8'd0;
          mem_err_d = 1'b1;
          halted_d  = 1'b1;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_WBSEL: state_d = S_WB;
      S_WB:    state_d = S_PCUPD;
      S_PCUPD: begin
        state_d   = S_FETCH;
        retired_d = retired_q + CNT_W'(1);
        if (bus.halt_req) halted_d = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      wait_q    <= 8'd0;
      mem_op_q  <= 1'b0;
      wr_q      <= 1'b0;
      halted_q  <= 1'b0;
      mem_err_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      mem_op_q  <= mem_op_d;
      wr_q      <= wr_d;
      halted_q  <= halted_d;
      mem_err_q <= mem_err_d;
      retired_q <= retired_d;
    end
  end

  // fetch_stb also depends on run, so it is gated by reset to keep strobes quiet while held.
  assign bus.fetch_stb  = rst_n && (state_q == S_FETCH) && bus.run && !halted_q;
  assign bus.decode_stb = (state_q == S_DECODE);
  assign bus.regrd_stb  = (state_q == S_REGRD);
  assign bus.exec_stb   = (state_q == S_EXEC);
  assign bus.mem_req    = (state_q == S_MEM) && mem_op_q;
  assign bus.wbsel_stb  = (state_q == S_WBSEL);
  assign bus.wb_stb     = (state_q == S_WB) && wr_q;
  assign bus.pc_stb     = (state_q == S_PCUPD);
  assign bus.state      = state_q;
  assign bus.busy       = (state_q != S_FETCH);
  assign bus.halted     = halted_q;
  assign bus.mem_err    = mem_err_q;
  assign bus.retired    = retired_q;

endmodule
